pe_config: RTL and testbench

PE_CONFIG -- requirements
Module: pe_config

---
 rtl/pe_config.sv | 306 ++++++++++++++++++++++++++++++
 tb/tb_pe_config.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/pe_config.sv
// pe_config: sequences the PE-array feed/drain and the TB/CB buffer ports
// through the PRD stage (nonlinear handshake, then three 12-cycle phases).
// Optional macro PE_CONFIG_NEW_UPD_STAGE_EN adds the NEW/UPD stages: each is
// a nonlinear wait followed by one PRD_1-shaped phase.
module pe_config #(
  parameter int X            = 4,
  parameter int Y            = 4,
  parameter int L            = 4,
  parameter int RSA_DW       = 16,
  parameter int TB_AW        = 12,
  parameter int CB_AW        = 19,
  parameter int MAX_LANDMARK = 500,
  parameter int GROUP_LEN    = 16
) (
  input  logic                   clk,
  input  logic                   sys_rst,
  input  logic [GROUP_LEN-1:0]   landmark_num,
  input  logic [GROUP_LEN-1:0]   cov_row_num,
  input  logic [GROUP_LEN-1:0]   group_num,
  input  logic [2:0]             stage_val,
  input  logic [2:0]             nonlinear_rdy,
  output logic [2:0]             stage_rdy,
  output logic [2:0]             nonlinear_val,
  output logic [X-1:0]           A_in_sel,
  output logic [X-1:0]           A_in_en,
  output logic [Y-1:0]           B_in_en,
  output logic [2*(Y-1):0]       B_in_sel,
  output logic [2*(X-1):0]       M_in_sel,
  output logic [X-1:0]           M_in_en,
  output logic [2*(X-1):0]       C_out_sel,
  output logic [X-1:0]           C_out_en,
  output logic [L-1:0]           TB_dinb_sel,
  output logic [L-1:0]           TB_douta_sel,
  output logic [L-1:0]           TB_doutb_sel,
  output logic [L-1:0]           TB_ena,
  output logic [L-1:0]           TB_enb,
  output logic [L-1:0]           TB_wea,
  output logic [L-1:0]           TB_web,
  output logic [L*RSA_DW-1:0]    init_TB_dina,
  output logic [L*TB_AW-1:0]     TB_addra,
  output logic [L*TB_AW-1:0]     TB_addrb,
  output logic [L-1:0]           CB_dinb_sel,
  output logic [L-1:0]           CB_douta_sel,
  output logic [L-1:0]           CB_doutb_sel,
  output logic [L-1:0]           CB_ena,
  output logic [L-1:0]           CB_enb,
  output logic [L-1:0]           CB_wea,
  output logic [L-1:0]           CB_web,
  output logic [L*RSA_DW-1:0]    init_CB_dina,
  output logic [L*RSA_DW-1:0]    CB_dinb,
  output logic [L*CB_AW-1:0]     CB_addra,
  output logic [L*CB_AW-1:0]     CB_addrb
);

  localparam int BW = 2*(Y-1)+1;
  localparam int CW = 2*(X-1)+1;
  localparam logic [L-1:0] LANE_MASK = L'(3'b111);
  localparam logic [X-1:0] X_MASK    = X'(3'b111);
  localparam logic [Y-1:0] Y_MASK    = Y'(3'b111);
  // TB row offsets of the working matrices
  localparam logic [3:0] F_XI   = 4'd0;
  localparam logic [3:0] F_XI_T = 4'd3;
  localparam logic [3:0] T_COV  = 4'd6;
  localparam logic [3:0] F_COV  = 4'd9;

  typedef enum logic [2:0] {
    IDLE,
    PRD_NONLINEAR,
    PRD_1,
    PRD_2,
    PRD_3
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
    ,
    NEW_NONLINEAR,
    UPD_NONLINEAR
`endif
  } state_t;

  state_t                state, state_nx;
  logic [3:0]            cnt, cnt_nx;
  logic                  latch;
  logic [GROUP_LEN-1:0]  landmark_q, cov_row_q, group_q;
  logic                  in_phase;
  logic [1:0]            sel;
  logic [3:0]            a_base, wr_base;
  logic                  unused_bits;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
  logic                  single_q, single_nx;
`endif

  // State, phase counter and latched stage parameters
  always_ff @(posedge clk or negedge sys_rst) begin
    if (!sys_rst) begin
      state      <= IDLE;
      cnt        <= '0;
      landmark_q <= '0;
      cov_row_q  <= '0;
      group_q    <= '0;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
      single_q   <= 1'b0;
`endif
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
      single_q <= single_nx;
`endif
      if (latch) begin
        landmark_q <= (landmark_num > GROUP_LEN'(MAX_LANDMARK)) ?
                      GROUP_LEN'(MAX_LANDMARK) : landmark_num;
        cov_row_q  <= cov_row_num;
        group_q    <= group_num;
      end
    end
  end

  // Next-state: stage request priority PRD > NEW > UPD, 12-cycle phases
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    latch    = 1'b0;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
    single_nx = single_q;
`endif
    case (state)
      IDLE: begin
        if (stage_val[0]) begin
          state_nx = PRD_NONLINEAR;
          latch    = 1'b1;
        end
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
        else if (stage_val[1]) begin
          state_nx = NEW_NONLINEAR;
          latch    = 1'b1;
        end else if (stage_val[2]) begin
          state_nx = UPD_NONLINEAR;
          latch    = 1'b1;
        end
`endif
      end
      PRD_NONLINEAR: begin
        if (nonlinear_rdy[0]) begin
          state_nx = PRD_1;
          cnt_nx   = '0;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
          single_nx = 1'b0;
`endif
        end
      end
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
      NEW_NONLINEAR: begin
        if (nonlinear_rdy[1]) begin
          state_nx  = PRD_1;
          cnt_nx    = '0;
          single_nx = 1'b1;
        end
      end
      UPD_NONLINEAR: begin
        if (nonlinear_rdy[2]) begin
          state_nx  = PRD_1;
          cnt_nx    = '0;
          single_nx = 1'b1;
        end
      end
`endif
      PRD_1, PRD_2, PRD_3: begin
        if (cnt == 4'd11) begin
          cnt_nx = '0;
          if (state == PRD_1) begin
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
            state_nx = single_q ? IDLE : PRD_2;
`else
            state_nx = PRD_2;
`endif
          end else if (state == PRD_2) begin
            state_nx = PRD_3;
          end else begin
            state_nx = IDLE;
          end
        end else begin
          cnt_nx = cnt + 4'd1;
        end
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Per-phase select value and buffer row bases
  always_comb begin
    in_phase = 1'b0;
    sel      = 2'd0;
    a_base   = F_XI;
    wr_base  = T_COV;
    case (state)
      PRD_1: begin in_phase = 1'b1; sel = 2'd0; a_base = F_XI;  wr_base = T_COV; end
      PRD_2: begin in_phase = 1'b1; sel = 2'd1; a_base = T_COV; wr_base = F_COV; end
      PRD_3: begin in_phase = 1'b1; sel = 2'd2; a_base = F_COV; wr_base = 4'd0;  end
      default: ;
    endcase
  end

  // Latched counts are kept for downstream stages; unused here
  always_comb begin
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
    unused_bits = ^{landmark_q, cov_row_q, group_q};
`else
    unused_bits = ^{landmark_q, cov_row_q, group_q, stage_val[2:1], nonlinear_rdy[2:1]};
`endif
  end

  // Output decode from state and phase counter
  always_comb begin
    stage_rdy     = (state == IDLE) ? 3'b111 : 3'b000;
    nonlinear_val = '0;
    A_in_sel      = '0;
    A_in_en       = '0;
    B_in_en       = '0;
    B_in_sel      = '0;
    M_in_sel      = '0;
    M_in_en       = '0;
    C_out_sel     = '0;
    C_out_en      = '0;
    TB_dinb_sel   = '0;
    TB_douta_sel  = '0;
    TB_doutb_sel  = '0;
    TB_ena        = '0;
    TB_enb        = '0;
    TB_wea        = '0;
    TB_web        = '0;
    init_TB_dina  = '0;
    TB_addra      = '0;
    TB_addrb      = '0;
    CB_dinb_sel   = '0;
    CB_douta_sel  = '0;
    CB_doutb_sel  = '0;
    CB_ena        = '0;
    CB_enb        = '0;
    CB_wea        = '0;
    CB_web        = '0;
    init_CB_dina  = '0;
    CB_dinb       = '0;
    CB_addra      = '0;
    CB_addrb      = '0;

    case (state)
      PRD_NONLINEAR: nonlinear_val = 3'b001;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
      NEW_NONLINEAR: nonlinear_val = 3'b010;
      UPD_NONLINEAR: nonlinear_val = 3'b100;
`endif
      default: ;
    endcase

    if (in_phase) begin
      // A comes from TB port a; B from CB port a (PRD_1) or TB port b (PRD_2)
      if (cnt <= 4'd2) begin
        TB_ena       = LANE_MASK;
        TB_douta_sel = L'(sel);
        for (int unsigned i = 0; i < 3; i++)
          TB_addra[i*TB_AW +: TB_AW] = TB_AW'(a_base) + TB_AW'(cnt);
        if (state == PRD_1) begin
          CB_ena       = LANE_MASK;
          CB_douta_sel = L'(sel);
          for (int unsigned i = 0; i < 3; i++)
            CB_addra[i*CB_AW +: CB_AW] = CB_AW'(cnt);
        end else if (state == PRD_2) begin
          TB_enb       = LANE_MASK;
          TB_doutb_sel = L'(sel);
          for (int unsigned i = 0; i < 3; i++)
            TB_addrb[i*TB_AW +: TB_AW] = TB_AW'(F_XI_T) + TB_AW'(cnt);
        end
      end
      // A_in_sel is one bit per lane, so only the low select bit survives
      if (cnt >= 4'd3 && cnt <= 4'd5) begin
        A_in_en  = X_MASK;
        A_in_sel = sel[0] ? X_MASK : '0;
        B_in_en  = Y_MASK;
        B_in_sel = BW'(sel);
      end
      if (cnt >= 4'd8 && cnt <= 4'd10) begin
        C_out_en  = X_MASK;
        C_out_sel = CW'(sel);
      end
      // Result write-back on port b; PRD_3 writes the covariance into CB
      if (cnt >= 4'd9) begin
        if (state == PRD_3) begin
          CB_enb      = LANE_MASK;
          CB_web      = LANE_MASK;
          CB_dinb_sel = L'(sel);
          for (int unsigned i = 0; i < 3; i++)
            CB_addrb[i*CB_AW +: CB_AW] = CB_AW'(cnt - 4'd9);
        end else begin
          TB_enb      = LANE_MASK;
          TB_web      = LANE_MASK;
          TB_dinb_sel = L'(sel);
          for (int unsigned i = 0; i < 3; i++)
            TB_addrb[i*TB_AW +: TB_AW] = TB_AW'(wr_base) + TB_AW'(cnt - 4'd9);
        end
      end
    end
  end

endmodule

// File: tb/tb_pe_config.sv
// tb_pe_config: directed bench for pe_config with an expected-value queue.
module tb_pe_config;

  localparam int X = 4, Y = 4, L = 4, RSA_DW = 16, TB_AW = 12, CB_AW = 19;
  localparam int GROUP_LEN = 16;

  logic clk;
  logic sys_rst;
  logic [GROUP_LEN-1:0] landmark_num, cov_row_num, group_num;
  logic [2:0] stage_val, nonlinear_rdy, stage_rdy, nonlinear_val;
  logic [X-1:0] A_in_sel, A_in_en, M_in_en, C_out_en;
  logic [Y-1:0] B_in_en;
  logic [2*(Y-1):0] B_in_sel;
  logic [2*(X-1):0] M_in_sel, C_out_sel;
  logic [L-1:0] TB_dinb_sel, TB_douta_sel, TB_doutb_sel, TB_ena, TB_enb, TB_wea, TB_web;
  logic [L-1:0] CB_dinb_sel, CB_douta_sel, CB_doutb_sel, CB_ena, CB_enb, CB_wea, CB_web;
  logic [L*RSA_DW-1:0] init_TB_dina, init_CB_dina, CB_dinb;
  logic [L*TB_AW-1:0] TB_addra, TB_addrb;
  logic [L*CB_AW-1:0] CB_addra, CB_addrb;
  logic others_any;

  int tests = 0;
  int fails = 0;
  string       tag_q[$];
  logic [63:0] exp_q[$];

  pe_config #(.X(X), .Y(Y), .L(L), .RSA_DW(RSA_DW), .TB_AW(TB_AW), .CB_AW(CB_AW),
              .MAX_LANDMARK(500), .GROUP_LEN(GROUP_LEN)) dut (
    .clk(clk), .sys_rst(sys_rst),
    .landmark_num(landmark_num), .cov_row_num(cov_row_num), .group_num(group_num),
    .stage_val(stage_val), .nonlinear_rdy(nonlinear_rdy),
    .stage_rdy(stage_rdy), .nonlinear_val(nonlinear_val),
    .A_in_sel(A_in_sel), .A_in_en(A_in_en), .B_in_en(B_in_en), .B_in_sel(B_in_sel),
    .M_in_sel(M_in_sel), .M_in_en(M_in_en), .C_out_sel(C_out_sel), .C_out_en(C_out_en),
    .TB_dinb_sel(TB_dinb_sel), .TB_douta_sel(TB_douta_sel), .TB_doutb_sel(TB_doutb_sel),
    .TB_ena(TB_ena), .TB_enb(TB_enb), .TB_wea(TB_wea), .TB_web(TB_web),
    .init_TB_dina(init_TB_dina), .TB_addra(TB_addra), .TB_addrb(TB_addrb),
    .CB_dinb_sel(CB_dinb_sel), .CB_douta_sel(CB_douta_sel), .CB_doutb_sel(CB_doutb_sel),
    .CB_ena(CB_ena), .CB_enb(CB_enb), .CB_wea(CB_wea), .CB_web(CB_web),
    .init_CB_dina(init_CB_dina), .CB_dinb(CB_dinb), .CB_addra(CB_addra), .CB_addrb(CB_addrb)
  );

  // Any output other than stage_rdy being nonzero
  assign others_any = |{nonlinear_val, A_in_sel, A_in_en, B_in_en, B_in_sel, M_in_sel,
                        M_in_en, C_out_sel, C_out_en, TB_dinb_sel, TB_douta_sel,
                        TB_doutb_sel, TB_ena, TB_enb, TB_wea, TB_web, init_TB_dina,
                        TB_addra, TB_addrb, CB_dinb_sel, CB_douta_sel, CB_doutb_sel,
                        CB_ena, CB_enb, CB_wea, CB_web, init_CB_dina, CB_dinb,
                        CB_addra, CB_addrb};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_v(input string tag, input logic [63:0] v);
    tag_q.push_back(tag);
    exp_q.push_back(v);
  endtask

  task automatic check(input logic [63:0] obs);
    string       tag;
    logic [63:0] exp;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $error("FAIL scoreboard_empty: observed %0h expected <none>", obs);
    end else begin
      exp = exp_q.pop_front();
      tag = tag_q.pop_front();
      assert (obs === exp) else begin
        fails++;
        $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
    end
  endtask

  initial begin
    sys_rst = 1'b0;
    stage_val = '0;
    nonlinear_rdy = '0;
    landmark_num = 16'd600;
    cov_row_num = 16'd12;
    group_num = 16'd3;

    // Reset held low for 2 cycles, then released
    tick(2);
    expect_v("rst_stage_rdy", 64'h7);  check(stage_rdy);
    expect_v("rst_quiet", 64'h0);      check(others_any);
    sys_rst = 1'b1;
    tick(1);
    expect_v("rel_stage_rdy", 64'h7);  check(stage_rdy);
    expect_v("rel_quiet", 64'h0);      check(others_any);

    // nonlinear_rdy has no effect in IDLE
    nonlinear_rdy = 3'b001;
    tick(1);
    nonlinear_rdy = '0;
    expect_v("idle_rdy_ignored", 64'h7); check(stage_rdy);

    // PRD request held for two cycles
    stage_val = 3'b001;
    tick(1);
    expect_v("req_stage_rdy", 64'h0);  check(stage_rdy);
    expect_v("req_nl_val", 64'h1);     check(nonlinear_val);
    tick(1);
    stage_val = '0;
    expect_v("req2_nl_val", 64'h1);    check(nonlinear_val);
    expect_v("req2_no_read", 64'h0);   check(TB_ena);

    // Nonlinear done ~10 cycles after the request
    tick(8);
    nonlinear_rdy = 3'b001;
    tick(1);
    nonlinear_rdy = '0;
    // PRD_1 cnt0
    expect_v("p1c0_tb_ena", 64'h7);    check(TB_ena);
    expect_v("p1c0_tb_addra", 64'h0);  check(TB_addra);
    expect_v("p1c0_cb_ena", 64'h7);    check(CB_ena);
    expect_v("p1c0_nl_val", 64'h0);    check(nonlinear_val);
    tick(3);  // PRD_1 cnt3
    expect_v("p1c3_a_en", 64'h7);      check(A_in_en);
    expect_v("p1c3_a_sel", 64'h0);     check(A_in_sel);
    expect_v("p1c3_b_en", 64'h7);      check(B_in_en);
    tick(6);  // PRD_1 cnt9
    expect_v("p1c9_tb_web", 64'h7);    check(TB_web);
    expect_v("p1c9_tb_addrb0", 64'd6); check(TB_addrb[11:0]);
    tick(3);  // PRD_2 cnt0
    expect_v("p2c0_tb_ena", 64'h7);    check(TB_ena);
    expect_v("p2c0_tb_addra0", 64'd6); check(TB_addra[11:0]);
    expect_v("p2c0_tb_enb", 64'h7);    check(TB_enb);
    expect_v("p2c0_tb_addrb0", 64'd3); check(TB_addrb[11:0]);
    expect_v("p2c0_doutb_sel", 64'h1); check(TB_doutb_sel);
    expect_v("p2c0_cb_ena", 64'h0);    check(CB_ena);
    tick(3);  // PRD_2 cnt3
    expect_v("p2c3_a_en", 64'h7);      check(A_in_en);
    expect_v("p2c3_a_sel", 64'h7);     check(A_in_sel);
    expect_v("p2c3_b_sel", 64'h1);     check(B_in_sel);
    tick(5);  // PRD_2 cnt8
    expect_v("p2c8_c_en", 64'h7);      check(C_out_en);
    expect_v("p2c8_c_sel", 64'h1);     check(C_out_sel);
    tick(1);  // PRD_2 cnt9
    expect_v("p2c9_tb_web", 64'h7);    check(TB_web);
    expect_v("p2c9_tb_addrb0", 64'd9); check(TB_addrb[11:0]);
    expect_v("p2c9_tb_addrb2", 64'd9); check(TB_addrb[35:24]);
    expect_v("p2c9_lane3", 64'h0);     check(TB_addrb[47:36]);
    tick(3);  // PRD_3 cnt0
    expect_v("p3c0_tb_addra0", 64'd9); check(TB_addra[11:0]);
    expect_v("p3c0_douta_sel", 64'h2); check(TB_douta_sel);
    tick(3);  // PRD_3 cnt3
    expect_v("p3c3_b_sel", 64'h2);     check(B_in_sel);
    tick(6);  // PRD_3 cnt9
    expect_v("p3c9_cb_web", 64'h7);    check(CB_web);
    expect_v("p3c9_cb_addrb0", 64'd0); check(CB_addrb[18:0]);
    expect_v("p3c9_tb_web", 64'h0);    check(TB_web);
    tick(2);  // PRD_3 cnt11
    expect_v("p3c11_cb_addrb2", 64'd2); check(CB_addrb[56:38]);
    expect_v("p3c11_busy", 64'h0);      check(stage_rdy);
    tick(1);  // 36 cycles after PRD_1 entry
    expect_v("done_stage_rdy", 64'h7);  check(stage_rdy);
    expect_v("done_quiet", 64'h0);      check(others_any);

    // Asynchronous reset in the middle of PRD_2
    stage_val = 3'b001;
    tick(1);
    stage_val = '0;
    nonlinear_rdy = 3'b001;
    tick(1);
    nonlinear_rdy = '0;
    tick(15);  // PRD_2 cnt3
    expect_v("mid_a_en", 64'h7);       check(A_in_en);
    #1 sys_rst = 1'b0;
    #1;
    expect_v("mid_rst_rdy", 64'h7);    check(stage_rdy);
    expect_v("mid_rst_quiet", 64'h0);  check(others_any);
    tick(2);
    sys_rst = 1'b1;
    tick(1);
    stage_val = 3'b001;
    tick(1);
    stage_val = '0;
    expect_v("post_rst_nl_val", 64'h1); check(nonlinear_val);
    nonlinear_rdy = 3'b001;
    tick(1);
    nonlinear_rdy = '0;
    tick(36);
    expect_v("post_rst_done", 64'h7);   check(stage_rdy);

    // Multiple requests: PRD wins
    stage_val = 3'b111;
    tick(1);
    stage_val = '0;
    expect_v("prio_nl_val", 64'h1);     check(nonlinear_val);
    sys_rst = 1'b0;
    tick(1);
    sys_rst = 1'b1;
    tick(1);

    // NEW stage request
    stage_val = 3'b010;
    tick(1);
    stage_val = '0;
`ifdef PE_CONFIG_NEW_UPD_STAGE_EN
    expect_v("new_nl_val", 64'h2);      check(nonlinear_val);
    expect_v("new_busy", 64'h0);        check(stage_rdy);
    tick(3);
    nonlinear_rdy = 3'b001;
    tick(1);
    nonlinear_rdy = '0;
    expect_v("new_wrong_rdy", 64'h2);   check(nonlinear_val);
    nonlinear_rdy = 3'b010;
    tick(1);
    nonlinear_rdy = '0;
    expect_v("new_p_tb_ena", 64'h7);    check(TB_ena);
    tick(11);
    expect_v("new_p_busy", 64'h0);      check(stage_rdy);
    tick(1);
    expect_v("new_p_done", 64'h7);      check(stage_rdy);
`else
    expect_v("new_ignored_nl", 64'h0);  check(nonlinear_val);
    expect_v("new_ignored_rdy", 64'h7); check(stage_rdy);
    stage_val = 3'b100;
    tick(1);
    stage_val = '0;
    expect_v("upd_ignored_nl", 64'h0);  check(nonlinear_val);
    expect_v("upd_ignored_rdy", 64'h7); check(stage_rdy);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
